// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU controller for the execute stage.
// Runs a radix-2 restoring division, one quotient bit per BUSY cycle, and
// returns quotient on the LO write port and remainder on the HI write port.
//
// Ports:
//   clock                     single clock, rising-edge state updates
//   reset                     asynchronous, active-low
//   start                     divide request (held while the pipeline stalls)
//   signed_div                1 = DIV, 0 = DIVU; sampled with start in IDLE
//   dividend / divisor        operands; sampled with start in IDLE
//   cancel                    pipeline flush; aborts the operation in progress
//   stall_request             holds the execute stage while a divide is in flight
//   result_ready              one-cycle pulse when HI/LO write data is valid
//   register_hi_write_enable  HI strobe (same as result_ready)
//   register_hi_write_data    remainder, 0 outside the DONE cycle
//   register_lo_write_enable  LO strobe (same as result_ready)
//   register_lo_write_data    quotient, 0 outside the DONE cycle
module div_sequencer #(
    parameter int unsigned ITERATIONS = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [ITERATIONS-1:0] dividend,
    input  logic [ITERATIONS-1:0] divisor,
    input  logic                  cancel,
    output logic                  stall_request,
    output logic                  result_ready,
    output logic                  register_hi_write_enable,
    output logic [ITERATIONS-1:0] register_hi_write_data,
    output logic                  register_lo_write_enable,
    output logic [ITERATIONS-1:0] register_lo_write_data
);

    localparam int unsigned W     = ITERATIONS;
    localparam int unsigned CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     rem_q;       // partial remainder (always < divisor magnitude)
    logic [W-1:0]     quo_q;       // dividend bits shift out the top, quotient bits in
    logic [W-1:0]     div_mag;     // divisor magnitude
    logic             q_neg;
    logic             r_neg;
    logic [W-1:0]     hi_data;
    logic [W-1:0]     lo_data;

    // Operand magnitudes; 0x80000000 maps to itself, read as unsigned.
    logic [W-1:0] dividend_mag;
    logic [W-1:0] divisor_mag;

    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        if (signed_div && dividend[W-1]) begin
            dividend_mag = ~dividend + W'(1);
        end
        if (signed_div && divisor[W-1]) begin
            divisor_mag = ~divisor + W'(1);
        end
    end

    // One restoring iteration; the shifted remainder needs W+1 bits so the
    // trial compare/subtract cannot overflow.
    logic [W:0]   shifted;
    logic [W-1:0] rem_next;
    logic [W-1:0] quo_next;

    always_comb begin
        shifted  = {rem_q, quo_q[W-1]};
        rem_next = W'(shifted);
        quo_next = {quo_q[W-2:0], 1'b0};
        if (shifted >= {1'b0, div_mag}) begin
            rem_next    = W'(shifted - {1'b0, div_mag});
            quo_next[0] = 1'b1;
        end
    end

    // Sign correction applied to the final iteration's results.
    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;

    always_comb begin
        quo_fix = q_neg ? (~quo_next + W'(1)) : quo_next;
        rem_fix = r_neg ? (~rem_next + W'(1)) : rem_next;
    end

    // Controller state, datapath registers and registered write data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_mag <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            hi_data <= '0;
            lo_data <= '0;
        end else if (cancel) begin
            // Flush wins in every state: abandon the operation, drop write data.
            state   <= IDLE;
            count   <= '0;
            hi_data <= '0;
            lo_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            state   <= DONE;
                            q_neg   <= 1'b0;
                            r_neg   <= 1'b0;
                            lo_data <= '1;
                            hi_data <= dividend;
                        end else begin
                            state   <= BUSY;
                            count   <= '0;
                            rem_q   <= '0;
                            quo_q   <= dividend_mag;
                            div_mag <= divisor_mag;
                            q_neg   <= signed_div & (dividend[W-1] ^ divisor[W-1]);
                            r_neg   <= signed_div & dividend[W-1];
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(ITERATIONS - 1)) begin
                        state   <= DONE;
                        lo_data <= quo_fix;
                        hi_data <= rem_fix;
                    end
                end
                DONE: begin
                    // Start seen here is ignored; the instruction retires this cycle.
                    state   <= IDLE;
                    hi_data <= '0;
                    lo_data <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write strobes decode DONE; a same-cycle flush suppresses the write.
    always_comb begin
        result_ready             = (state == DONE) && !cancel;
        register_hi_write_enable = result_ready;
        register_lo_write_enable = result_ready;
        register_hi_write_data   = hi_data;
        register_lo_write_data   = lo_data;
    end

    // Stall covers the accepting IDLE cycle and all of BUSY; forced low in reset.
    always_comb begin
        stall_request = reset &&
                        (((state == IDLE) && start && !cancel) || (state == BUSY));
    end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall_request;
    logic        result_ready;
    logic        register_hi_write_enable;
    logic [31:0] register_hi_write_data;
    logic        register_lo_write_enable;
    logic [31:0] register_lo_write_data;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [63:0] exp_q[$];   // {remainder, quotient}

    div_sequencer #(.ITERATIONS(32)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .start                    (start),
        .signed_div               (signed_div),
        .dividend                 (dividend),
        .divisor                  (divisor),
        .cancel                   (cancel),
        .stall_request            (stall_request),
        .result_ready             (result_ready),
        .register_hi_write_enable (register_hi_write_enable),
        .register_hi_write_data   (register_hi_write_data),
        .register_lo_write_enable (register_lo_write_enable),
        .register_lo_write_data   (register_lo_write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Scoreboard: every write pulse must match the oldest expected result.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (result_ready) begin
                check("hi_we", 64'(register_hi_write_enable), 64'd1);
                check("lo_we", 64'(register_lo_write_enable), 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("lo_data", 64'(register_lo_write_data), 64'(e[31:0]));
                    check("hi_data", 64'(register_hi_write_data), 64'(e[63:32]));
                end
            end
        end
    end

    // Issue one divide in the next cycle and measure latency and stall length.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat);
        int  cyc = 0;
        int  stalls = 0;
        bit  seen = 0;
        @(posedge clock); #1;
        start = 1'b1; signed_div = s; dividend = a; divisor = b; cancel = 1'b0;
        exp_q.push_back(model(s, a, b));
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (stall_request) stalls++;
            if (result_ready) begin
                seen = 1;
                cyc = i;
                break;
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        if (!seen) check("timeout", 64'd0, 64'd1);
        check("latency", 64'(cyc), 64'(exp_lat));
        check("stall_cycles", 64'(stalls), 64'(exp_lat));
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check("idle_ready", 64'(result_ready), 64'd0);
        check("idle_stall", 64'(stall_request), 64'd0);
        check("idle_data", {register_hi_write_data, register_lo_write_data}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0; cancel = 1'b0;
        #12;
        check("reset_outputs", {28'd0, stall_request, result_ready,
               register_hi_write_enable, register_lo_write_enable}, 64'd0);
        check("reset_data", {register_hi_write_data, register_lo_write_data}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 33);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 33);
        run_div(1'b0, 32'h0000_1234, 32'd0, 1);
        run_div(1'b1, 32'h8000_0000, 32'd0, 1);
        for (int k = 0; k < 4; k++) begin
            run_div(1'(k), $urandom, $urandom_range(1, 32'hFFFF), 33);
        end

        // Cancel mid-BUSY at T+10, restart in the following cycle.
        @(posedge clock); #1;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1 cancel = 1'b1;
        @(negedge clock);
        check("cancel_busy_ready", 64'(result_ready), 64'd0);
        run_div(1'b0, 32'd50, 32'd6, 33);

        // Cancel during DONE: write strobes gated in that cycle.
        @(posedge clock); #1;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (32) @(posedge clock);
        #1 cancel = 1'b1;
        @(negedge clock);
        check("cancel_done_ready", 64'(result_ready), 64'd0);
        check("cancel_done_we", {62'd0, register_hi_write_enable, register_lo_write_enable}, 64'd0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 33);

        // Asynchronous reset at T+5 mid-BUSY.
        @(posedge clock); #1;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_reset_flags", {28'd0, stall_request, result_ready,
               register_hi_write_enable, register_lo_write_enable}, 64'd0);
        check("async_reset_data", {register_hi_write_data, register_lo_write_data}, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_div(1'b0, 32'd9, 32'd3, 33);

        repeat (3) @(posedge clock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
